// File: rtl/approx_mul_arbiter.sv
// approx_mul_arbiter: round-robin share of one 8x8 approximate multiplier across NREQ requesters.
// Define EXACT_MUL_EN to replace the approximate product with the exact x*y.
module approx_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_x,
  input  logic [8*NREQ-1:0] req_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_z,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       ops_cnt
);
  logic [7:0]     r_x1, r_y1;
  logic [IDW-1:0] r_id1, r_ptr, w_gid;
  logic           r_v1, w_found, w_adv, w_s1_acc, w_xfer;
  logic [15:0]    w_z;

  assign w_adv    = !rsp_valid | rsp_ready;
  assign w_s1_acc = w_adv | !r_v1;

  // first valid requester at or above the pointer, wrapping modulo NREQ
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_gid   = IDW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign req_ready = (w_found & w_s1_acc & rst_n) ? {{(NREQ-1){1'b0}}, 1'b1} << w_gid : '0;
  assign w_xfer    = |req_ready;

`ifdef EXACT_MUL_EN
  assign w_z = 16'(r_x1) * 16'(r_y1);
`else
  assign w_z = ((16'(r_y1) * 16'(r_x1[7:2])) << 2)
             + {7'd0, (r_x1[0] & r_y1[7]) | (r_x1[1] & r_y1[6]), 8'd0}
             + {7'd0, r_x1[1] & r_y1[7], 8'd0};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x1      <= '0;
      r_y1      <= '0;
      r_id1     <= '0;
      r_v1      <= 1'b0;
      r_ptr     <= '0;
      rsp_valid <= 1'b0;
      rsp_z     <= '0;
      rsp_id    <= '0;
      ops_cnt   <= '0;
    end else begin
      if (w_xfer) begin
        r_x1  <= req_x[int'(w_gid)*8 +: 8];
        r_y1  <= req_y[int'(w_gid)*8 +: 8];
        r_id1 <= w_gid;
        r_ptr <= (int'(w_gid) == NREQ-1) ? '0 : w_gid + 1'b1;
      end
      r_v1 <= w_xfer | (r_v1 & !w_adv);
      if (w_adv) begin
        rsp_valid <= r_v1;
        rsp_z     <= w_z;
        rsp_id    <= r_id1;
      end
      if (rsp_valid & rsp_ready) ops_cnt <= ops_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_approx_mul_arbiter.sv
// tb_approx_mul_arbiter: directed checks of arbitration, pipeline timing, backpressure and reset.
module tb_approx_mul_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_x = '0;
  logic [31:0] req_y = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_z;
  logic [1:0]  rsp_id;
  logic [15:0] ops_cnt;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] rr_z [4] = '{16'd4, 16'd16, 16'd36, 16'd64};

  approx_mul_arbiter #(.NREQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_id(rsp_id), .ops_cnt(ops_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rr_operands();
    for (int i = 0; i < 4; i++) begin
      req_x[i*8 +: 8] = 8'(4 * (i + 1));
      req_y[i*8 +: 8] = 8'(i + 1);
    end
  endtask

  task automatic pulse_reset();
    #1 rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req_valid = 4'hF;
    #2;
    n_checks++;
    if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready got=%h exp=0", req_ready); end
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_z !== 16'd0 || rsp_id !== 2'd0 || ops_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b z=%0d id=%0d cnt=%0d exp all 0", rsp_valid, rsp_z, rsp_id, ops_cnt);
    end
    req_valid = '0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_ops();
    logic [1:0]  ids [3] = '{2'd2, 2'd0, 2'd3};
    logic [7:0]  xs  [3] = '{8'hFF, 8'h03, 8'h41};
    logic [7:0]  ys  [3] = '{8'hFF, 8'h05, 8'hC0};
`ifdef EXACT_MUL_EN
    logic [15:0] zs  [3] = '{16'd65025, 16'd15, 16'd12480};
`else
    logic [15:0] zs  [3] = '{16'd64772, 16'd0, 16'd12544};
`endif
    rsp_ready = 1'b1;
    for (int v = 0; v < 3; v++) begin
      req_x = '0;
      req_y = '0;
      req_x[ids[v]*8 +: 8] = xs[v];
      req_y[ids[v]*8 +: 8] = ys[v];
      req_valid = 4'b0001 << ids[v];
      #1;
      n_checks++;
      if (req_ready !== (4'b0001 << ids[v])) begin n_fail++; $display("FAIL single_ready[%0d] got=%b exp=%b", v, req_ready, 4'b0001 << ids[v]); end
      step();
      req_valid = '0;
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency[%0d] rsp_valid got=%b exp=0", v, rsp_valid); end
      step();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== ids[v] || rsp_z !== zs[v]) begin
        n_fail++;
        $display("FAIL single_rsp[%0d] got v=%b id=%0d z=%0d exp v=1 id=%0d z=%0d", v, rsp_valid, rsp_id, rsp_z, ids[v], zs[v]);
      end
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain[%0d] rsp_valid got=%b exp=0", v, rsp_valid); end
    end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    load_rr_operands();
    rsp_ready = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) begin
        n_checks++;
        if (req_ready !== 4'(1 << (c % 4))) begin n_fail++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, req_ready, 4'(1 << (c % 4))); end
      end
      step();
      if (c >= 1) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 1) % 4) || rsp_z !== rr_z[(c - 1) % 4]) begin
          n_fail++;
          $display("FAIL rr_rsp[%0d] got v=%b id=%0d z=%0d exp v=1 id=%0d z=%0d", c - 1, rsp_valid, rsp_id, rsp_z, (c - 1) % 4, rr_z[(c - 1) % 4]);
        end
      end
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || ops_cnt !== 16'd8) begin n_fail++; $display("FAIL rr_count got v=%b cnt=%0d exp v=0 cnt=8", rsp_valid, ops_cnt); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_first got=%b exp=0001", req_ready); end
    step();
    n_checks++;
    if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_second got=%b exp=0010", req_ready); end
    step();
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if (req_ready !== 4'h0 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_z !== rr_z[0]) begin
        n_fail++;
        $display("FAIL bp_stall[%0d] got rdy=%b v=%b id=%0d z=%0d exp rdy=0000 v=1 id=0 z=%0d", s, req_ready, rsp_valid, rsp_id, rsp_z, rr_z[0]);
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_resume got=%b exp=0100", req_ready); end
    step();
    req_valid = '0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_z !== rr_z[1]) begin
      n_fail++;
      $display("FAIL bp_drain1 got v=%b id=%0d z=%0d exp v=1 id=1 z=%0d", rsp_valid, rsp_id, rsp_z, rr_z[1]);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_z !== rr_z[2]) begin
      n_fail++;
      $display("FAIL bp_drain2 got v=%b id=%0d z=%0d exp v=1 id=2 z=%0d", rsp_valid, rsp_id, rsp_z, rr_z[2]);
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0 || ops_cnt !== 16'd11) begin n_fail++; $display("FAIL bp_count got v=%b cnt=%0d exp v=0 cnt=11", rsp_valid, ops_cnt); end
  endtask

  task automatic test_reset_inflight();
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    step();
    step();
    n_checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 4'h0) begin n_fail++; $display("FAIL rst_setup got v=%b rdy=%b exp v=1 rdy=0000", rsp_valid, req_ready); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || ops_cnt !== 16'd0 || req_ready !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_async got v=%b cnt=%0d rdy=%b exp v=0 cnt=0 rdy=0000", rsp_valid, ops_cnt, req_ready);
    end
    step();
    rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stale[%0d] rsp_valid got=%b exp=0", s, rsp_valid); end
    end
    req_valid = 4'hF;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001 || ops_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_ptr got rdy=%b cnt=%0d exp rdy=0001 cnt=0", req_ready, ops_cnt); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_round_robin();
    test_backpressure();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
